fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of control_unit and the decode stage. It owns the PC, issues one instruction-memory request at a time and buffers the returned word with its PC in a single-entry IF/ID output register. It applies redirects using the same 2-bit PC_mux encoding that control_unit produces.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
redirect_valid  in  1  redirect request from decode/execute this cycle
pc_sel  in  2  PC_mux code: 00 seq, 01 JAL, 10 JALR, 11 branch
redirect_pc  in  XLEN  PC of the redirecting instruction
imm  in  XLEN  sign-extended immediate of the redirecting instruction
rs1_val  in  XLEN  rs1 operand (JALR only)
branch_taken  in  1  branch comparison result (pc_sel=11 only)
halt  in  1  ECALL/EBREAK seen; stop fetching
imem_req  out  1  one-cycle read request strobe
imem_addr  out  XLEN  request address (= pc)
imem_rdata  in  32  returned instruction
imem_rvalid  in  1  response strobe; latency of 1 cycle or more
id_valid  out  1  output register holds a valid instruction
id_inst  out  32  buffered instruction
id_pc  out  XLEN  PC of id_inst
id_ready  in  1  decode consumes id_inst this cycle
misaligned  out  1  sticky flag: redirect target[1:0] != 0

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=REQ, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0, imem_req=0, misaligned=0.
- States: REQ, WAIT, FULL, DRAIN, HALTED. Only one request may be outstanding.
- REQ: imem_req=1 and imem_addr=pc for exactly one cycle, then go to WAIT. In every other state imem_req=0.
- WAIT, on imem_rvalid: id_inst<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4, go to FULL.
- FULL: hold all outputs stable while id_ready=0. On id_ready: id_valid<=0, go to REQ. Steady-state throughput is one instruction per 3 cycles at 1-cycle memory latency.
- DRAIN: wait for imem_rvalid, drop the data, go to REQ. Used to discard the stale in-flight response after a redirect.
- Effective redirect = redirect_valid & (pc_sel==01 | pc_sel==10 | (pc_sel==11 & branch_taken)). pc_sel=00, or 11 with branch not taken, has no effect.
- Target computation, all arithmetic modulo 2^XLEN:
  - 01 and 11: redirect_pc+imm.
  - 10: (rs1_val+imm) & ~1.
- Effective redirect, any state except HALTED:
  - pc<=target and id_valid<=0 (same-cycle id_ready is ignored).
  - From REQ or WAIT: go to DRAIN, unless imem_rvalid is high in that same WAIT cycle, in which case drop the response and go to REQ.
  - From FULL or DRAIN: go to REQ if no response is outstanding. If DRAIN sees imem_rvalid in the same cycle, go to REQ; otherwise stay in DRAIN.
- Target with target[1:0] != 0: misaligned<=1, id_valid<=0, go to HALTED.
- halt has priority over redirect, in any state: id_valid<=0, go to HALTED. Late imem_rvalid is ignored there. Only rst exits HALTED.
- Simultaneous id_ready and redirect: the redirect wins and the instruction is treated as flushed.

Decomposition:
- Shared package: PC_mux codes (PC_SEQ=2'b00, PC_JAL=2'b01, PC_JALR=2'b10, PC_BR=2'b11), fetch state encoding, NOP constant 32'h0000_0013, RESET_PC default.
- One sub-module: next_pc_calc, combinational. Inputs are pc_sel, redirect_pc, imm, rs1_val and branch_taken; outputs are take and target.

Test Plan:
- Reset, 1-cycle memory, id_ready=1 always -> imem_addr sequence 0,4,8 with one request every 3 cycles; id_pc matches each address and id_inst equals the memory word.
- Hold id_ready=0 for 5 cycles after the first response -> id_valid, id_inst and id_pc are stable, imem_req=0; on release the next request goes to address 4.
- Redirect in WAIT with pc_sel=01, redirect_pc=0x10, imm=0x20 while memory latency is 3 -> the stale word is dropped and never appears on id_*; the next request is to 0x30.
- pc_sel=10, rs1_val=0x101, imm=0x4 -> next address 0x104. pc_sel=11 with branch_taken=0 -> the sequence is unaffected.
- pc_sel=01, redirect_pc=0, imm=0x6 -> misaligned=1, state HALTED, no further imem_req. Assert rst mid-WAIT -> outputs return to reset values asynchronously, then fetch restarts at RESET_PC.
- halt asserted together with a redirect in FULL -> HALTED, id_valid=0, no request issued. Later imem_rvalid pulses have no effect.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: PC_mux codes, fetch FSM states and reset constants shared by
// the fetch stage and its neighbours.
package fetch_unit_pkg;
   localparam logic [1:0]  PC_SEQ           = 2'b00;
   localparam logic [1:0]  PC_JAL           = 2'b01;
   localparam logic [1:0]  PC_JALR          = 2'b10;
   localparam logic [1:0]  PC_BR            = 2'b11;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   typedef enum logic [2:0] {S_REQ, S_WAIT, S_FULL, S_DRAIN, S_HALTED} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response and IF/ID output bundle.
interface fetch_unit_if #(parameter int XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_rvalid;
   logic            id_valid;
   logic [31:0]     id_inst;
   logic [XLEN-1:0] id_pc;
   logic            id_ready;
   modport master (output imem_req, imem_addr, id_valid, id_inst, id_pc,
                   input  imem_rdata, imem_rvalid, id_ready);
   modport slave  (input  imem_req, imem_addr, id_valid, id_inst, id_pc,
                   output imem_rdata, imem_rvalid, id_ready);
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// fetch_unit_next_pc_calc: decodes a PC_mux code into a take flag and the
// redirect target address.
module fetch_unit_next_pc_calc
   import fetch_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_val,
   input  logic            branch_taken,
   output logic            take,
   output logic [XLEN-1:0] target
);
   logic [XLEN-1:0] jalr_sum;
   assign jalr_sum = rs1_val + imm;
   assign take     = (pc_sel == PC_JAL) || (pc_sel == PC_JALR) || (pc_sel == PC_BR && branch_taken);
   assign target   = (pc_sel == PC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : redirect_pc + imm;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, keeps one imem request in flight at a time and buffers
// the returned word with its PC in a single-entry IF/ID register.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_val,
   input  logic            branch_taken,
   input  logic            halt,
   fetch_unit_if.master    bus,
   output logic            misaligned
);
   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, id_pc_q, id_pc_d, target;
   logic [31:0]     id_inst_q, id_inst_d;
   logic            id_valid_q, id_valid_d, req_q, mis_q, mis_d, take, redirect, in_flight;

   fetch_unit_next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
      .pc_sel       (pc_sel),
      .redirect_pc  (redirect_pc),
      .imm          (imm),
      .rs1_val      (rs1_val),
      .branch_taken (branch_taken),
      .take         (take),
      .target       (target)
   );

   assign redirect  = redirect_valid && take;
   // a response is still owed unless it is on the bus this very cycle
   assign in_flight = req_q || ((state_q == S_WAIT || state_q == S_DRAIN) && !bus.imem_rvalid);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_valid_d = id_valid_q;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      mis_d      = mis_q;
      if (state_q != S_HALTED) begin
         if (halt) begin
            id_valid_d = 1'b0;
            state_d    = S_HALTED;
         end else if (redirect) begin
            id_valid_d = 1'b0;
            if (target[1:0] != 2'b00) begin
               mis_d   = 1'b1;
               state_d = S_HALTED;
            end else begin
               pc_d    = target;
               state_d = in_flight ? S_DRAIN : S_REQ;
            end
         end else begin
            case (state_q)
               S_REQ:   state_d = req_q ? S_WAIT : S_REQ;
               S_WAIT:  if (bus.imem_rvalid) begin
                  id_inst_d  = bus.imem_rdata;
                  id_pc_d    = pc_q;
                  id_valid_d = 1'b1;
                  pc_d       = pc_q + XLEN'(4);
                  state_d    = S_FULL;
               end
               S_FULL:  if (bus.id_ready) begin
                  id_valid_d = 1'b0;
                  state_d    = S_REQ;
               end
               S_DRAIN: state_d = bus.imem_rvalid ? S_REQ : S_DRAIN;
               default: state_d = state_q;
            endcase
         end
      end
   end

   // the strobe is registered, so the first REQ cycle after reset is spent raising it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         id_valid_q <= 1'b0;
         id_inst_q  <= NOP_INST;
         id_pc_q    <= '0;
         req_q      <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_valid_q <= id_valid_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         req_q      <= (state_d == S_REQ);
         mis_q      <= mis_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign bus.id_valid  = id_valid_q;
   assign bus.id_inst   = id_inst_q;
   assign bus.id_pc     = id_pc_q;
   assign misaligned    = mis_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage and a variable-latency memory.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid, branch_taken, halt, misaligned;
   logic [1:0]  pc_sel;
   logic [31:0] redirect_pc, imm, rs1_val;
   int          n_vec = 0;
   int          n_err = 0;
   bit          rdy = 1'b1;
   int          lat_mode = 1;
   bit          m_halted, m_mis, m_bv, m_infl, m_stale, m_issue;
   logic [31:0] m_pc, m_bi, m_bp;
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   fetch_unit_if #(.XLEN(32)) bus ();

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .pc_sel         (pc_sel),
      .redirect_pc    (redirect_pc),
      .imm            (imm),
      .rs1_val        (rs1_val),
      .branch_taken   (branch_taken),
      .halt           (halt),
      .bus            (bus),
      .misaligned     (misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      {m_halted, m_mis, m_bv, m_infl, m_stale, m_issue} = '0;
      m_pc     = 32'h0;
      mem_busy = 1'b0;
   endtask

   // Transaction view: at most one request in flight, a buffer slot, and a
   // "stale" mark on a request whose answer must be thrown away.
   task automatic model_step();
      bit          take;
      logic [31:0] tgt;
      if (m_halted) return;
      take = redirect_valid && (pc_sel == 2'd1 || pc_sel == 2'd2 || (pc_sel == 2'd3 && branch_taken));
      tgt  = (pc_sel == 2'd2) ? ((rs1_val + imm) & 32'hFFFF_FFFE) : (redirect_pc + imm);
      if (halt) begin
         m_bv = 0; m_halted = 1; m_issue = 0;
         return;
      end
      if (take) begin
         m_bv = 0;
         if (tgt % 4 != 0) begin
            m_mis = 1; m_halted = 1; m_issue = 0;
            return;
         end
         m_pc = tgt;
         if (m_issue) begin m_infl = 1; m_stale = 1; end
         else if (m_infl && bus.imem_rvalid) m_infl = 0;
         else if (m_infl) m_stale = 1;
         m_issue = !m_infl;
         return;
      end
      if (m_issue) begin
         m_infl = 1; m_stale = 0; m_issue = 0;
         return;
      end
      if (m_infl && bus.imem_rvalid) begin
         m_infl = 0;
         if (!m_stale) begin
            m_bv = 1; m_bi = bus.imem_rdata; m_bp = m_pc; m_pc = m_pc + 4;
         end
         m_stale = 0;
      end else if (m_bv && bus.id_ready) m_bv = 0;
      m_issue = !m_infl && !m_bv;
   endtask

   task automatic idle();
      redirect_valid = 0; halt = 0; branch_taken = 0; pc_sel = 2'd0;
      redirect_pc = 0; imm = 0; rs1_val = 0;
      bus.id_ready = rdy;
   endtask

   task automatic tick();
      check("imem_req", 32'(bus.imem_req), 32'(m_issue));
      if (m_issue) check("imem_addr", bus.imem_addr, m_pc);
      check("id_valid", 32'(bus.id_valid), 32'(m_bv));
      if (m_bv) begin
         check("id_inst", bus.id_inst, m_bi);
         check("id_pc", bus.id_pc, m_bp);
      end
      check("misaligned", 32'(misaligned), 32'(m_mis));
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mem_addr);
            mem_busy        = 1'b0;
         end
      end
      if (m_halted && $urandom_range(3) == 0) bus.imem_rvalid = 1'b1;
      if (m_issue) begin
         mem_busy = 1'b1;
         mem_addr = m_pc;
         mem_cnt  = (lat_mode != 0) ? lat_mode : int'($urandom_range(3, 1));
      end
      model_step();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin idle(); tick(); end
   endtask

   task automatic wait_issue();
      for (int i = 0; i < 30 && !m_issue; i++) begin idle(); tick(); end
      check("wait_issue", 32'(bus.imem_req), 32'd1);
   endtask

   task automatic wait_full();
      for (int i = 0; i < 30 && !m_bv; i++) begin idle(); tick(); end
      check("wait_full", 32'(bus.id_valid), 32'd1);
   endtask

   // Raised mid-cycle so the outputs must fall before any clock edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_valid", 32'(bus.id_valid), 32'd0);
      check("rst_inst", bus.id_inst, NOP_INST);
      check("rst_id_pc", bus.id_pc, 32'd0);
      check("rst_addr", bus.imem_addr, 32'd0);
      check("rst_mis", 32'(misaligned), 32'd0);
      bus.imem_rvalid = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      idle();
   endtask

   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      idle();
      @(negedge clk);
      do_reset();
      // sequential fetch, 1-cycle memory, one request every 3 cycles
      wait_issue();
      check("seq0", bus.imem_addr, 32'h0);
      run(3);
      check("seq1", bus.imem_addr, 32'h4);
      run(3);
      check("seq2", bus.imem_addr, 32'h8);
      // decode stall holds the buffer
      do_reset();
      rdy = 0;
      wait_full();
      run(5);
      check("hold_pc", bus.id_pc, 32'h0);
      check("hold_inst", bus.id_inst, mem_word(32'h0));
      rdy = 1;
      wait_issue();
      check("hold_next", bus.imem_addr, 32'h4);
      // JAL redirect while waiting on a slow memory
      do_reset();
      lat_mode = 3;
      wait_issue();
      run(1);
      idle(); redirect_valid = 1; pc_sel = PC_JAL; redirect_pc = 32'h10; imm = 32'h20;
      tick();
      wait_issue();
      check("jal_addr", bus.imem_addr, 32'h30);
      // JALR from a full buffer, then a not-taken branch
      lat_mode = 1;
      wait_full();
      idle(); redirect_valid = 1; pc_sel = PC_JALR; rs1_val = 32'h101; imm = 32'h4;
      tick();
      wait_issue();
      check("jalr_addr", bus.imem_addr, 32'h104);
      wait_full();
      idle(); redirect_valid = 1; pc_sel = PC_BR; branch_taken = 0; redirect_pc = 32'h500; imm = 32'h40;
      tick();
      wait_issue();
      check("br_nt_addr", bus.imem_addr, 32'h108);
      // misaligned target halts
      wait_full();
      idle(); redirect_valid = 1; pc_sel = PC_JAL; redirect_pc = 32'h0; imm = 32'h6;
      tick();
      run(6);
      check("mis_flag", 32'(misaligned), 32'd1);
      check("mis_valid", 32'(bus.id_valid), 32'd0);
      // reset in the middle of a memory wait, then restart from RESET_PC
      do_reset();
      lat_mode = 3;
      wait_issue();
      run(1);
      do_reset();
      wait_issue();
      check("restart", bus.imem_addr, 32'h0);
      // halt beats a same-cycle redirect
      lat_mode = 1;
      wait_full();
      idle(); halt = 1; redirect_valid = 1; pc_sel = PC_JAL; redirect_pc = 32'h40; imm = 32'h8;
      tick();
      run(8);
      check("halt_valid", 32'(bus.id_valid), 32'd0);
      check("halt_req", 32'(bus.imem_req), 32'd0);
      // randomized traffic
      do_reset();
      lat_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         if ((m_halted && $urandom_range(7) == 0) || $urandom_range(599) == 0) begin
            do_reset();
         end else begin
            bus.id_ready   = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(11) == 0);
            pc_sel         = 2'($urandom);
            branch_taken   = 1'($urandom);
            redirect_pc    = $urandom & 32'h0000_0FFC;
            imm            = $urandom & (($urandom_range(15) == 0) ? 32'h0000_0FFF : 32'h0000_0FFC);
            rs1_val        = $urandom & (($urandom_range(15) == 0) ? 32'h0000_0FFF : 32'h0000_0FFD);
            halt           = ($urandom_range(199) == 0);
            tick();
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
